vend_change_dispenser: RTL

Returns change to the customer after a vend. It takes a change amount in currency units and drives a two-denomination coin hopper (large coin = LARGE_COIN units, small coin = 1 unit) one coin at a time. Each drop is confirmed by the hopper before the next coin. It sits downstream of the vending controller's item/coin logic and reports completion, or a hopper fault, back to it.

---
 rtl/vend_change_dispenser.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/vend_change_dispenser.sv
// Change dispenser: pays out an amount as large/small coins through a hopper,
// one coin at a time. Each coin waits for the hopper's acknowledge, with a timeout.
module vend_change_dispenser #(
    parameter int AMT_W       = 8,
    parameter int LARGE_COIN  = 5,
    parameter int PULSE_LEN   = 4,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req,
    input  logic [AMT_W-1:0] change_amt,
    input  logic             hopper_ack,
    input  logic             clr_fault,
    output logic             coin_large,
    output logic             coin_small,
    output logic             busy,
    output logic             done,
    output logic             fault,
    output logic [AMT_W-1:0] remaining,
    output logic [AMT_W-1:0] n_large,
    output logic [AMT_W-1:0] n_small
);

    localparam int PW = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
    localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [PW-1:0]    PULSE_LAST = PW'(PULSE_LEN - 1);
    localparam logic [PW-1:0]    PULSE_ONE  = PW'(1);
    localparam logic [TW-1:0]    ACK_LAST   = TW'(ACK_TIMEOUT - 1);
    localparam logic [TW-1:0]    ACK_ONE    = TW'(1);
    localparam logic [AMT_W-1:0] LARGE_VAL  = AMT_W'(LARGE_COIN);
    localparam logic [AMT_W-1:0] AMT_ONE    = AMT_W'(1);
    localparam logic [AMT_W-1:0] AMT_ZERO   = AMT_W'(0);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SELECT   = 3'd1,
        PULSE    = 3'd2,
        WAIT_ACK = 3'd3,
        DONE     = 3'd4,
        FAULT    = 3'd5
    } state_t;

    state_t           state_r, state_s;
    logic             sel_large_r, sel_large_s;
    logic [PW-1:0]    pulse_cnt_r, pulse_cnt_s;
    logic [TW-1:0]    ack_cnt_r, ack_cnt_s;
    logic [AMT_W-1:0] remaining_r, remaining_s;
    logic [AMT_W-1:0] n_large_r, n_large_s;
    logic [AMT_W-1:0] n_small_r, n_small_s;
    logic             coin_large_r, coin_large_s;
    logic             coin_small_r, coin_small_s;
    logic             busy_r, busy_s;
    logic             done_r, done_s;
    logic             fault_r, fault_s;

    // Next-state, datapath and output decode; outputs follow the next state so they register cleanly
    always_comb begin
        state_s     = state_r;
        sel_large_s = sel_large_r;
        pulse_cnt_s = pulse_cnt_r;
        ack_cnt_s   = ack_cnt_r;
        remaining_s = remaining_r;
        n_large_s   = n_large_r;
        n_small_s   = n_small_r;

        case (state_r)
            IDLE: begin
                if (req) begin
                    remaining_s = change_amt;
                    n_large_s   = AMT_ZERO;
                    n_small_s   = AMT_ZERO;
                    if (change_amt == AMT_ZERO) begin
                        state_s = DONE;
                    end else begin
                        state_s = SELECT;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            SELECT: begin
                // Greedy choice: large only when it cannot overdraw the balance
                sel_large_s = (remaining_r >= LARGE_VAL);
                pulse_cnt_s = {PW{1'b0}};
                state_s     = PULSE;
            end
            PULSE: begin
                if (pulse_cnt_r == PULSE_LAST) begin
                    ack_cnt_s = {TW{1'b0}};
                    state_s   = WAIT_ACK;
                end else begin
                    pulse_cnt_s = pulse_cnt_r + PULSE_ONE;
                end
            end
            WAIT_ACK: begin
                // An ack on the last allowed cycle still wins over the timeout
                if (hopper_ack) begin
                    if (sel_large_r) begin
                        remaining_s = remaining_r - LARGE_VAL;
                        n_large_s   = n_large_r + AMT_ONE;
                    end else begin
                        remaining_s = remaining_r - AMT_ONE;
                        n_small_s   = n_small_r + AMT_ONE;
                    end
                    if (remaining_s == AMT_ZERO) begin
                        state_s = DONE;
                    end else begin
                        state_s = SELECT;
                    end
                end else if (ack_cnt_r == ACK_LAST) begin
                    state_s = FAULT;
                end else begin
                    ack_cnt_s = ack_cnt_r + ACK_ONE;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            FAULT: begin
                if (clr_fault) begin
                    state_s = IDLE;
                end else begin
                    state_s = FAULT;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        coin_large_s = (state_s == PULSE) && sel_large_s;
        coin_small_s = (state_s == PULSE) && !sel_large_s;
        busy_s       = (state_s != IDLE);
        done_s       = (state_s == DONE);
        fault_s      = (state_s == FAULT);
    end

    // State, datapath and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            sel_large_r  <= 1'b0;
            pulse_cnt_r  <= {PW{1'b0}};
            ack_cnt_r    <= {TW{1'b0}};
            remaining_r  <= AMT_ZERO;
            n_large_r    <= AMT_ZERO;
            n_small_r    <= AMT_ZERO;
            coin_large_r <= 1'b0;
            coin_small_r <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            fault_r      <= 1'b0;
        end else begin
            state_r      <= state_s;
            sel_large_r  <= sel_large_s;
            pulse_cnt_r  <= pulse_cnt_s;
            ack_cnt_r    <= ack_cnt_s;
            remaining_r  <= remaining_s;
            n_large_r    <= n_large_s;
            n_small_r    <= n_small_s;
            coin_large_r <= coin_large_s;
            coin_small_r <= coin_small_s;
            busy_r       <= busy_s;
            done_r       <= done_s;
            fault_r      <= fault_s;
        end
    end

    assign coin_large = coin_large_r;
    assign coin_small = coin_small_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign fault      = fault_r;
    assign remaining  = remaining_r;
    assign n_large    = n_large_r;
    assign n_small    = n_small_r;

endmodule
